// File: rtl/mem_req_ctrl_if.sv
// Bundle of request, response and memory-pin signals for mem_req_ctrl.
// The slave modport is the controller's view; master is the surrounding system's.
interface mem_req_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LEN_WIDTH-1:0]  req_len;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic                  rsp_last;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_wdata,
        input  rsp_ready, mem_data_out,
        output req_ready,
        output rsp_valid, rsp_data, rsp_addr, rsp_last,
        output mem_read, mem_write, mem_addr, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, req_wdata,
        output rsp_ready, mem_data_out,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_addr, rsp_last,
        input  mem_read, mem_write, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of a synchronous single-port memory: turns single
// and burst read/fill commands into one-cycle memory strobes and read responses.
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_req_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d;
    logic [LEN_WIDTH-1:0]  left_q, left_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_in_q, mem_data_in_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_last_q, rsp_last_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;

    logic                  accept;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] cur_inc;

    assign bus.req_ready   = (state_q == IDLE) && !reset;
    assign accept          = bus.req_valid && bus.req_ready;
    assign last_beat       = (left_q == '0);
    assign cur_inc         = cur_q + ADDR_WIDTH'(1);

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_addr    = rsp_addr_q;

    // Strobes default low so each beat's read or write lasts exactly one cycle.
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        left_d        = left_q;
        wdata_d       = wdata_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_last_d    = rsp_last_q;
        rsp_data_d    = rsp_data_q;
        rsp_addr_d    = rsp_addr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cur_d      = bus.req_addr;
                    left_d     = bus.req_len;
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = bus.req_addr;
                    if (bus.req_write) begin
                        state_d       = WR;
                        mem_write_d   = 1'b1;
                        mem_data_in_d = bus.req_wdata;
                    end else begin
                        state_d    = RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (last_beat) begin
                    state_d = IDLE;
                end else begin
                    left_d        = left_q - LEN_WIDTH'(1);
                    cur_d         = cur_inc;
                    mem_write_d   = 1'b1;
                    mem_addr_d    = cur_inc;
                    mem_data_in_d = wdata_q;
                end
            end
            RD: begin
                state_d = RWAIT;
            end
            // Memory output is valid during this cycle and is captured at its end.
            RWAIT: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = bus.mem_data_out;
                rsp_addr_d  = cur_q;
                rsp_last_d  = last_beat;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = RD;
                        left_d     = left_q - LEN_WIDTH'(1);
                        cur_d      = cur_inc;
                        mem_read_d = 1'b1;
                        mem_addr_d = cur_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            left_q        <= '0;
            wdata_q       <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_last_q    <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            left_q        <= left_d;
            wdata_q       <= wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_last_q    <= rsp_last_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
        end
    end

    // The memory must never see read and write together, nor a strobe outside its beat.
    assert property (@(posedge clk) !(mem_read_q && mem_write_q));
    assert property (@(posedge clk) mem_write_q |-> (state_q == WR));
    assert property (@(posedge clk) mem_read_q |-> (state_q == RD));
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized bench for mem_req_ctrl: a transaction-level model predicts memory
// pin activity and read responses per cycle; literal expectations pin key cases.
module tb_mem_req_ctrl;
    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int LW    = 2;
    localparam int DEPTH = 1 << AW;

    localparam int F_RSP_VALID = 0;
    localparam int F_RSP_DATA  = 1;
    localparam int F_RSP_ADDR  = 2;
    localparam int F_RSP_LAST  = 3;
    localparam int F_REQ_READY = 4;
    localparam int F_MEM_READ  = 5;
    localparam int F_MEM_WRITE = 6;
    localparam int F_MEM_ADDR  = 7;
    localparam int F_MEM_DIN   = 8;

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } pin_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            left;
        logic [DW-1:0] data;
        int            due;
    } beat_t;

    typedef struct {
        int          cyc;
        int          field;
        logic [31:0] value;
        string       name;
    } lit_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;

    mem_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_cyc = 0;
    int timeouts = 0;
    int timeouts_seen = 0;
    int ready_mode = 1;
    int stall_cnt = 0;

    pin_t          pin_q[$];
    beat_t         rsp_q[$];
    lit_t          lit_q[$];
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 37 + 11);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous 32x8 memory the controller drives.
    always @(posedge clk) begin
        if (mem_init === 1'b1) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else begin
            if (bus.mem_write === 1'b1) mem[bus.mem_addr] <= bus.mem_data_in;
            if (bus.mem_read === 1'b1) bus.mem_data_out <= mem[bus.mem_addr];
        end
    end

    // Response consumer: random, always ready, or five stall cycles per beat.
    always begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
        end else if (ready_mode == 1) begin
            bus.rsp_ready = 1'b1;
        end else if (bus.rsp_ready === 1'b1) begin
            stall_cnt     = 0;
            bus.rsp_ready = 1'b0;
        end else if (bus.rsp_valid === 1'b1) begin
            stall_cnt     = stall_cnt + 1;
            bus.rsp_ready = (stall_cnt > 5);
        end else begin
            bus.rsp_ready = 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] field_val(input int f);
        case (f)
            F_RSP_VALID: return 32'(bus.rsp_valid);
            F_RSP_DATA:  return 32'(bus.rsp_data);
            F_RSP_ADDR:  return 32'(bus.rsp_addr);
            F_RSP_LAST:  return 32'(bus.rsp_last);
            F_REQ_READY: return 32'(bus.req_ready);
            F_MEM_READ:  return 32'(bus.mem_read);
            F_MEM_WRITE: return 32'(bus.mem_write);
            F_MEM_ADDR:  return 32'(bus.mem_addr);
            default:     return 32'(bus.mem_data_in);
        endcase
    endfunction

    // Compare process: literal pins, then model expectations, then model update.
    always @(negedge clk) begin
        pin_t          e;
        beat_t         b;
        logic [AW-1:0] na;
        bit            exp_ready;
        bit            exp_valid;

        if (mem_init === 1'b1)
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

        foreach (lit_q[i])
            if (lit_q[i].cyc == cyc)
                check_output(lit_q[i].name, field_val(lit_q[i].field), lit_q[i].value);

        if (timeouts != timeouts_seen) begin
            check_output("wait_timeout", 32'(timeouts), 32'(timeouts_seen));
            timeouts_seen = timeouts;
        end

        exp_ready = (reset === 1'b0) && (pin_q.size() == 0) && (rsp_q.size() == 0);
        check_output("req_ready", 32'(bus.req_ready), 32'(exp_ready));

        if (pin_q.size() > 0) e = pin_q.pop_front();
        else e = '{1'b0, 1'b0, AW'(0), DW'(0)};
        check_output("mem_read", 32'(bus.mem_read), 32'(e.rd));
        check_output("mem_write", 32'(bus.mem_write), 32'(e.wr));
        if (e.rd || e.wr) check_output("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        if (e.wr) begin
            check_output("mem_data_in", 32'(bus.mem_data_in), 32'(e.data));
            ref_mem[e.addr] = e.data;
        end

        exp_valid = (rsp_q.size() > 0) && (rsp_q[0].due <= cyc);
        check_output("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_output("rsp_data", 32'(bus.rsp_data), 32'(rsp_q[0].data));
            check_output("rsp_addr", 32'(bus.rsp_addr), 32'(rsp_q[0].addr));
            check_output("rsp_last", 32'(bus.rsp_last), 32'(rsp_q[0].left == 0));
        end

        if (reset !== 1'b0) begin
            pin_q.delete();
            rsp_q.delete();
        end else begin
            if (exp_valid && bus.rsp_ready === 1'b1) begin
                b = rsp_q.pop_front();
                if (b.left > 0) begin
                    na = AW'(b.addr + 1);
                    pin_q.push_back('{1'b1, 1'b0, na, DW'(0)});
                    rsp_q.push_back('{na, b.left - 1, ref_mem[na], cyc + 3});
                end
            end
            if (exp_ready && bus.req_valid === 1'b1) begin
                acc_cnt = acc_cnt + 1;
                acc_cyc = cyc;
                if (bus.req_write) begin
                    for (int i = 0; i <= int'(bus.req_len); i++)
                        pin_q.push_back('{1'b0, 1'b1, AW'(int'(bus.req_addr) + i), bus.req_wdata});
                end else begin
                    pin_q.push_back('{1'b1, 1'b0, bus.req_addr, DW'(0)});
                    rsp_q.push_back('{bus.req_addr, int'(bus.req_len), ref_mem[bus.req_addr], cyc + 3});
                end
            end
        end
    end

    task automatic expect_at(input int c, input string nm, input int f, input logic [31:0] v);
        lit_q.push_back('{c, f, v, nm});
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(pin_q.size() == 0 && rsp_q.size() == 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) timeouts = timeouts + 1;
    endtask

    task automatic apply_stimulus(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                                  input logic [DW-1:0] d, input bit noise);
        int start = acc_cnt;
        int n = 0;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_len   = l;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        while (acc_cnt == start && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.req_valid = 1'b0;
        if (acc_cnt == start) timeouts = timeouts + 1;
        if (noise) begin
            bus.req_write = 1'($urandom_range(0, 1));
            bus.req_addr  = AW'($urandom);
            bus.req_len   = LW'($urandom);
            bus.req_wdata = DW'($urandom);
            bus.req_valid = 1'b1;
            idle_cycles(1);
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        int            k;
        int            c;
        int            exp_addrs[4];
        logic [AW-1:0] ra;

        exp_addrs = '{30, 31, 0, 1};
        reset         = 1'b1;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;

        expect_at(2, "rst_rsp_valid", F_RSP_VALID, 0);
        expect_at(2, "rst_rsp_data", F_RSP_DATA, 0);
        expect_at(2, "rst_rsp_addr", F_RSP_ADDR, 0);
        expect_at(2, "rst_rsp_last", F_RSP_LAST, 0);
        expect_at(2, "rst_req_ready", F_REQ_READY, 0);
        expect_at(2, "rst_mem_read", F_MEM_READ, 0);
        expect_at(2, "rst_mem_write", F_MEM_WRITE, 0);
        expect_at(2, "rst_mem_addr", F_MEM_ADDR, 0);
        expect_at(2, "rst_mem_din", F_MEM_DIN, 0);
        idle_cycles(3);
        mem_init = 1'b0;
        reset    = 1'b0;
        idle_cycles(2);

        $display("[TB] single write then read at address 5");
        apply_stimulus(1'b1, 5'd5, 2'd0, 8'hA5, 1'b0);
        k = acc_cyc;
        expect_at(k + 1, "wr1_mem_write", F_MEM_WRITE, 1);
        expect_at(k + 1, "wr1_mem_addr", F_MEM_ADDR, 5);
        expect_at(k + 1, "wr1_mem_din", F_MEM_DIN, 32'hA5);
        expect_at(k + 2, "wr1_mem_write_end", F_MEM_WRITE, 0);
        expect_at(k + 2, "wr1_ready_again", F_REQ_READY, 1);
        wait_idle();
        apply_stimulus(1'b0, 5'd5, 2'd0, 8'h00, 1'b0);
        k = acc_cyc;
        expect_at(k + 1, "rd1_mem_read", F_MEM_READ, 1);
        expect_at(k + 1, "rd1_mem_addr", F_MEM_ADDR, 5);
        expect_at(k + 2, "rd1_mem_read_end", F_MEM_READ, 0);
        expect_at(k + 2, "rd1_not_yet_valid", F_RSP_VALID, 0);
        expect_at(k + 3, "rd1_rsp_valid", F_RSP_VALID, 1);
        expect_at(k + 3, "rd1_rsp_data", F_RSP_DATA, 32'hA5);
        expect_at(k + 3, "rd1_rsp_addr", F_RSP_ADDR, 5);
        expect_at(k + 3, "rd1_rsp_last", F_RSP_LAST, 1);
        wait_idle();

        $display("[TB] wrapping fill and read burst at address 30");
        apply_stimulus(1'b1, 5'd30, 2'd3, 8'h3C, 1'b0);
        k = acc_cyc;
        for (int i = 0; i < 4; i++) begin
            expect_at(k + 1 + i, "fill_mem_write", F_MEM_WRITE, 1);
            expect_at(k + 1 + i, "fill_mem_addr", F_MEM_ADDR, 32'(exp_addrs[i]));
        end
        expect_at(k + 5, "fill_done_ready", F_REQ_READY, 1);
        wait_idle();
        apply_stimulus(1'b0, 5'd30, 2'd3, 8'h00, 1'b0);
        k = acc_cyc;
        for (int i = 0; i < 4; i++) begin
            expect_at(k + 1 + 3 * i, "burst_mem_read", F_MEM_READ, 1);
            expect_at(k + 3 + 3 * i, "burst_rsp_valid", F_RSP_VALID, 1);
            expect_at(k + 3 + 3 * i, "burst_rsp_addr", F_RSP_ADDR, 32'(exp_addrs[i]));
            expect_at(k + 3 + 3 * i, "burst_rsp_data", F_RSP_DATA, 32'h3C);
            expect_at(k + 3 + 3 * i, "burst_rsp_last", F_RSP_LAST, 32'(i == 3));
        end
        wait_idle();

        $display("[TB] stalled read burst");
        ready_mode = 2;
        apply_stimulus(1'b0, 5'd12, 2'd2, 8'h00, 1'b0);
        wait_idle();

        $display("[TB] request pulses during an active burst");
        ready_mode = 0;
        apply_stimulus(1'b0, 5'd3, 2'd3, 8'h00, 1'b1);
        wait_idle();
        apply_stimulus(1'b1, 5'd20, 2'd2, 8'h77, 1'b1);
        wait_idle();

        $display("[TB] reset while a response is held");
        ready_mode = 2;
        apply_stimulus(1'b0, 5'd28, 2'd3, 8'h00, 1'b0);
        idle_cycles(2);
        reset = 1'b1;
        c = cyc;
        idle_cycles(1);
        reset = 1'b0;
        expect_at(c + 1, "rstmid_rsp_valid", F_RSP_VALID, 0);
        expect_at(c + 1, "rstmid_rsp_data", F_RSP_DATA, 0);
        expect_at(c + 1, "rstmid_req_ready", F_REQ_READY, 1);
        ready_mode = 1;
        wait_idle();
        apply_stimulus(1'b0, 5'd31, 2'd1, 8'h00, 1'b0);
        wait_idle();

        $display("[TB] reset held with a pending request");
        reset         = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 5'd9;
        bus.req_len   = 2'd1;
        bus.req_wdata = 8'hEE;
        bus.req_valid = 1'b1;
        c = cyc;
        for (int i = 0; i < 6; i++) begin
            expect_at(c + i, "rsthold_req_ready", F_REQ_READY, 0);
            expect_at(c + i, "rsthold_mem_write", F_MEM_WRITE, 0);
        end
        idle_cycles(6);
        bus.req_valid = 1'b0;
        reset         = 1'b0;
        expect_at(c + 6, "rsthold_ready_after", F_REQ_READY, 1);
        idle_cycles(2);

        $display("[TB] randomized command mix");
        for (int n = 0; n < 40; n++) begin
            ready_mode = int'($urandom_range(0, 2));
            ra = AW'($urandom);
            apply_stimulus(1'($urandom_range(0, 1)), ra, LW'($urandom), DW'($urandom),
                           ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 7) == 0) begin
                idle_cycles(int'($urandom_range(1, 6)));
                reset = 1'b1;
                idle_cycles(1);
                reset = 1'b0;
            end
            wait_idle();
            idle_cycles(int'($urandom_range(0, 2)));
        end

        idle_cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
